ifmap_gin_dispatcher: RTL and testbench
=======================================

IFMAP_GIN_DISPATCHER -- requirements
Module: ifmap_gin_dispatcher

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH 16 ifmap word; NUM_ROWS 12 PE rows; NUM_COLS 14 PEs per row; ROW_TAG_WIDTH 4; COL_TAG_WIDTH 5; CNT_WIDTH 16 word counter.
REQ-002 SHALL have ports (name direction width meaning), clock and reset first:
 clk  in  1  single clock; all state on rising edge.
 reset_n  in  1  asynchronous, active-low reset.
 start  in  1  one-cycle pulse; begins a pass.
 total_words  in  CNT_WIDTH  words in the pass; sampled on start.
 in_data  in  DATA_WIDTH  ifmap word from GLB FIFO.
 in_valid / in_ready  in / out  1  upstream handshake.
 row_tag / col_tag  in  ROW_TAG_WIDTH / COL_TAG_WIDTH  current tag from the ifmap tag generator.
 tag_enable  out  1  advances the tag generator.
 pe_row_id  in  NUM_ROWS*ROW_TAG_WIDTH  configured row ID per PE row.
 pe_col_id  in  NUM_ROWS*NUM_COLS*COL_TAG_WIDTH  configured column ID per PE.
 pe_ready  in  NUM_ROWS*NUM_COLS  PE can accept an ifmap word.
 pe_enable  out  NUM_ROWS*NUM_COLS  one-cycle write strobe per PE.
 out_data  out  DATA_WIDTH  broadcast ifmap bus.
 busy / done  out  1  pass active / one-cycle pass-complete pulse.

Function
REQ-003 SHALL implement FSM IDLE, RUN, DRAIN; start in IDLE latches total_words, clears accepted count, moves to RUN; start outside IDLE ignored.
REQ-004 SHALL hold a one-entry output register {data, row_tag, col_tag, out_valid}; out_data driven from it.
REQ-005 Upstream accept (in_valid && in_ready) SHALL load in_data with the row_tag/col_tag present that cycle, set out_valid, increment accepted count.
REQ-006 tag_enable SHALL equal in_valid && in_ready (exactly one tag advance per accepted word, same cycle).
REQ-007 Target mask: PE (i,j) targeted iff pe_row_id[i]==held row tag and pe_col_id[i][j]==held col tag.
REQ-008 Deliver when out_valid and every targeted PE has pe_ready=1; pe_enable = mask on that cycle only, else all zero.
REQ-009 Empty mask SHALL deliver in one cycle with pe_enable all zero (word dropped, still counted).
REQ-010 in_ready = (state==RUN) && accepted<total_words && (!out_valid || deliver); pass-through in the same cycle as delivery SHALL be supported (one word/cycle).
REQ-011 accepted==total_words in RUN SHALL move to DRAIN; DRAIN leaves when out_valid clears, pulsing done for one cycle and returning to IDLE.
REQ-012 total_words==0 SHALL go IDLE->RUN->DRAIN->done with no handshakes, no tag_enable.
REQ-013 busy=1 in RUN and DRAIN; accepted count width CNT_WIDTH, no wrap (limited by total_words).
REQ-014 Any targeted PE not ready SHALL stall: register, mask and tags held, in_ready=0, no partial delivery.

Reset
REQ-015 reset_n low SHALL asynchronously force IDLE, out_valid=0, counters 0, held data/tags 0; in_ready, tag_enable, pe_enable, busy, done all 0.
REQ-016 Reset mid-pass SHALL discard the held word with no pe_enable; next pass requires a new start.

Structure
REQ-017 State enum and default width constants SHALL live in the shared NoC package.
REQ-018 Per-PE tag compare SHALL be sub-module ifmap_multicast_match (row tag, col tag, IDs in; match out), instantiated per PE.

Verification
REQ-019 total_words=4, all PEs ready, tags (0,0),(0,1),(1,0),(1,1), one PE per ID -> one pe_enable per word, one word/cycle, done one cycle after last delivery.
REQ-020 Three PEs same IDs (2,3), one pe_ready=0 for 5 cycles -> no pe_enable, in_ready=0 for 5 cycles, then all three strobed together.
REQ-021 Tag (15,31) matching no PE -> word consumed in one cycle, pe_enable zero, count advances.
REQ-022 in_valid toggling 1,0,1 with total_words=2 -> tag_enable exactly twice, aligned to accepts.
REQ-023 reset_n low for 1 cycle while out_valid=1 -> outputs zero immediately, no pe_enable; start ignored in RUN.
REQ-024 total_words=0 -> done pulse, zero tag_enable/in_ready activity.

Source files
------------

// File: rtl/ifmap_gin_dispatcher_pkg.sv
// Shared NoC definitions for the ifmap global-input-network dispatcher:
// default width constants and the dispatcher state encoding.
package ifmap_gin_dispatcher_pkg;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_NUM_ROWS      = 12;
    localparam int DEF_NUM_COLS      = 14;
    localparam int DEF_ROW_TAG_WIDTH = 4;
    localparam int DEF_COL_TAG_WIDTH = 5;
    localparam int DEF_CNT_WIDTH     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } disp_state_e;

endpackage

// File: rtl/ifmap_gin_dispatcher_multicast_match.sv
// Per-PE multicast address compare: a PE is a target of the held word when
// both its row ID and its column ID equal the word's tags.
module ifmap_multicast_match #(
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 5
) (
    input  logic [ROW_TAG_WIDTH-1:0] row_tag,
    input  logic [COL_TAG_WIDTH-1:0] col_tag,
    input  logic [ROW_TAG_WIDTH-1:0] row_id,
    input  logic [COL_TAG_WIDTH-1:0] col_id,
    output logic                     match
);

    // Both tag fields must agree for this PE to be selected.
    always_comb begin
        match = 1'b0;
        if ((row_tag == row_id) && (col_tag == col_id)) begin
            match = 1'b1;
        end else begin
            match = 1'b0;
        end
    end

endmodule

// File: rtl/ifmap_gin_dispatcher.sv
// Ifmap GIN dispatcher: takes ifmap words from the GLB FIFO, tags each with
// the current row/col tag, and multicasts it to every PE whose configured
// IDs match, once all those PEs are ready. One word per cycle when unstalled.
module ifmap_gin_dispatcher
    import ifmap_gin_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_ROWS      = DEF_NUM_ROWS,
    parameter int NUM_COLS      = DEF_NUM_COLS,
    parameter int ROW_TAG_WIDTH = DEF_ROW_TAG_WIDTH,
    parameter int COL_TAG_WIDTH = DEF_COL_TAG_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      start,
    input  logic [CNT_WIDTH-1:0]                      total_words,
    input  logic [DATA_WIDTH-1:0]                     in_data,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [ROW_TAG_WIDTH-1:0]                  row_tag,
    input  logic [COL_TAG_WIDTH-1:0]                  col_tag,
    output logic                                      tag_enable,
    input  logic [NUM_ROWS*ROW_TAG_WIDTH-1:0]         pe_row_id,
    input  logic [NUM_ROWS*NUM_COLS*COL_TAG_WIDTH-1:0] pe_col_id,
    input  logic [NUM_ROWS*NUM_COLS-1:0]              pe_ready,
    output logic [NUM_ROWS*NUM_COLS-1:0]              pe_enable,
    output logic [DATA_WIDTH-1:0]                     out_data,
    output logic                                      busy,
    output logic                                      done
);

    localparam int NUM_PE = NUM_ROWS * NUM_COLS;

    disp_state_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]     total_q, total_d;
    logic [CNT_WIDTH-1:0]     accepted_q, accepted_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [ROW_TAG_WIDTH-1:0] row_q, row_d;
    logic [COL_TAG_WIDTH-1:0] col_q, col_d;
    logic                     out_valid_q, out_valid_d;

    logic [NUM_PE-1:0]        mask_s;
    logic                     stall_s;
    logic                     deliver_s;
    logic                     in_ready_s;
    logic                     accept_s;
    logic                     done_s;

    // Target mask built from one tag comparator per PE against the held tags.
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < NUM_COLS; gj++) begin : g_col
            ifmap_multicast_match #(
                .ROW_TAG_WIDTH (ROW_TAG_WIDTH),
                .COL_TAG_WIDTH (COL_TAG_WIDTH)
            ) u_match (
                .row_tag (row_q),
                .col_tag (col_q),
                .row_id  (pe_row_id[gi*ROW_TAG_WIDTH +: ROW_TAG_WIDTH]),
                .col_id  (pe_col_id[(gi*NUM_COLS+gj)*COL_TAG_WIDTH +: COL_TAG_WIDTH]),
                .match   (mask_s[gi*NUM_COLS+gj])
            );
        end
    end

    // Delivery and upstream handshake: all-or-nothing multicast, with a new
    // word accepted in the same cycle the held one leaves.
    always_comb begin
        stall_s    = |(mask_s & ~pe_ready);
        deliver_s  = out_valid_q && !stall_s;
        in_ready_s = (state_q == ST_RUN) && (accepted_q < total_q) &&
                     (!out_valid_q || deliver_s);
        accept_s   = in_valid && in_ready_s;
        if (deliver_s) begin
            pe_enable = mask_s;
        end else begin
            pe_enable = '0;
        end
    end

    // Next-state for the pass FSM, word counter and the one-entry holding register.
    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        accepted_d  = accepted_q;
        data_d      = data_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        done_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    total_d    = total_words;
                    accepted_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accepted_q == total_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_q) begin
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_s) begin
            data_d      = in_data;
            row_d       = row_tag;
            col_d       = col_tag;
            out_valid_d = 1'b1;
            accepted_d  = accepted_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else if (deliver_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any held word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            total_q     <= '0;
            accepted_q  <= '0;
            data_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            accepted_q  <= accepted_d;
            data_q      <= data_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign tag_enable = accept_s;
    assign out_data   = data_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_s;

endmodule

// File: tb/tb_ifmap_gin_dispatcher.sv
// Directed bench for ifmap_gin_dispatcher: multicast delivery, stall,
// dropped words, tag-advance alignment, reset mid-pass and empty pass.
module tb_ifmap_gin_dispatcher;

    localparam int DW  = 16;
    localparam int NR  = 12;
    localparam int NC  = 14;
    localparam int RTW = 4;
    localparam int CTW = 5;
    localparam int CW  = 16;
    localparam int NPE = NR * NC;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [CW-1:0]     total_words;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [RTW-1:0]    row_tag;
    logic [CTW-1:0]    col_tag;
    logic              tag_enable;
    logic [NR*RTW-1:0] pe_row_id;
    logic [NPE*CTW-1:0] pe_col_id;
    logic [NPE-1:0]    pe_ready;
    logic [NPE-1:0]    pe_enable;
    logic [DW-1:0]     out_data;
    logic              busy;
    logic              done;

    int compared;
    int mismatched;
    int tag_pulses;

    ifmap_gin_dispatcher #(
        .DATA_WIDTH    (DW),
        .NUM_ROWS      (NR),
        .NUM_COLS      (NC),
        .ROW_TAG_WIDTH (RTW),
        .COL_TAG_WIDTH (CTW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .total_words (total_words),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .row_tag     (row_tag),
        .col_tag     (col_tag),
        .tag_enable  (tag_enable),
        .pe_row_id   (pe_row_id),
        .pe_col_id   (pe_col_id),
        .pe_ready    (pe_ready),
        .pe_enable   (pe_enable),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count tag advances seen at each clock edge.
    always @(posedge clk) begin
        if (tag_enable === 1'b1) tag_pulses <= tag_pulses + 1;
    end

    task automatic chk(input string tag, input logic [NPE-1:0] obs, input logic [NPE-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NPE-1:0] bit_at(input int idx);
        logic [NPE-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        int tp0;
        logic [NPE-1:0] m3;
        compared    = 0;
        mismatched  = 0;
        tag_pulses  = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        total_words = '0;
        in_data     = '0;
        in_valid    = 1'b1;
        row_tag     = '0;
        col_tag     = '0;
        pe_ready    = '1;
        for (int i = 0; i < NR; i++) begin
            pe_row_id[i*RTW +: RTW] = (i < 3) ? RTW'(i) : 4'd14;
        end
        for (int i = 0; i < NPE; i++) pe_col_id[i*CTW +: CTW] = 5'd30;
        pe_col_id[0*CTW +: CTW]  = 5'd0;
        pe_col_id[1*CTW +: CTW]  = 5'd1;
        pe_col_id[14*CTW +: CTW] = 5'd0;
        pe_col_id[15*CTW +: CTW] = 5'd1;
        pe_col_id[28*CTW +: CTW] = 5'd3;
        pe_col_id[29*CTW +: CTW] = 5'd3;
        pe_col_id[30*CTW +: CTW] = 5'd3;
        m3 = bit_at(28) | bit_at(29) | bit_at(30);

        // Reset state, with in_valid asserted
        settle();
        chk("rst_in_ready", NPE'(in_ready), '0);
        chk("rst_tag_en", NPE'(tag_enable), '0);
        chk("rst_pe_en", pe_enable, '0);
        chk("rst_busy", NPE'(busy), '0);
        chk("rst_done", NPE'(done), '0);
        chk("rst_out_data", NPE'(out_data), '0);
        step();
        reset_n  = 1'b1;
        in_valid = 1'b0;

        // Four words to four single PEs, streamed one per cycle
        step(); start = 1'b1; total_words = 16'd4;
        step(); start = 1'b0; in_valid = 1'b1; in_data = 16'hA000; row_tag = 4'd0; col_tag = 5'd0;
        settle();
        chk("p1_c1_in_ready", NPE'(in_ready), NPE'(1));
        chk("p1_c1_tag_en", NPE'(tag_enable), NPE'(1));
        chk("p1_c1_pe_en", pe_enable, '0);
        step(); in_data = 16'hA001; row_tag = 4'd0; col_tag = 5'd1;
        settle();
        chk("p1_c2_pe_en", pe_enable, bit_at(0));
        chk("p1_c2_in_ready", NPE'(in_ready), NPE'(1));
        chk("p1_c2_data", NPE'(out_data), NPE'(16'hA000));
        step(); in_data = 16'hA002; row_tag = 4'd1; col_tag = 5'd0;
        settle();
        chk("p1_c3_pe_en", pe_enable, bit_at(1));
        step(); in_data = 16'hA003; row_tag = 4'd1; col_tag = 5'd1;
        settle();
        chk("p1_c4_pe_en", pe_enable, bit_at(14));
        chk("p1_c4_tag_en", NPE'(tag_enable), NPE'(1));
        step(); in_data = 16'hA004;
        settle();
        chk("p1_c5_pe_en", pe_enable, bit_at(15));
        chk("p1_c5_in_ready", NPE'(in_ready), '0);
        chk("p1_c5_tag_en", NPE'(tag_enable), '0);
        chk("p1_c5_data", NPE'(out_data), NPE'(16'hA003));
        chk("p1_c5_done", NPE'(done), '0);
        step(); in_valid = 1'b0;
        settle();
        chk("p1_c6_done", NPE'(done), NPE'(1));
        chk("p1_c6_busy", NPE'(busy), NPE'(1));
        step();
        settle();
        chk("p1_c7_done", NPE'(done), '0);
        chk("p1_c7_busy", NPE'(busy), '0);

        // Three-PE multicast stalled by one not-ready PE, then a word
        // whose tag (15,31) matches no PE
        step(); start = 1'b1; total_words = 16'd2;
        step(); start = 1'b0; in_valid = 1'b1; in_data = 16'hB000; row_tag = 4'd2; col_tag = 5'd3;
        pe_ready = ~bit_at(29);
        settle();
        chk("p2_acc0", NPE'(tag_enable), NPE'(1));
        step(); in_data = 16'hB001; row_tag = 4'd15; col_tag = 5'd31;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("p2_stall_pe_en", pe_enable, '0);
            chk("p2_stall_in_ready", NPE'(in_ready), '0);
            chk("p2_stall_tag_en", NPE'(tag_enable), '0);
            chk("p2_stall_data", NPE'(out_data), NPE'(16'hB000));
            if (k < 4) step();
            else begin
                step();
                pe_ready = '1;
            end
        end
        settle();
        chk("p2_mcast_pe_en", pe_enable, m3);
        chk("p2_mcast_in_ready", NPE'(in_ready), NPE'(1));
        step(); in_valid = 1'b0;
        settle();
        chk("p2_drop_pe_en", pe_enable, '0);
        chk("p2_drop_data", NPE'(out_data), NPE'(16'hB001));
        chk("p2_drop_busy", NPE'(busy), NPE'(1));
        step();
        settle();
        chk("p2_done", NPE'(done), NPE'(1));

        // in_valid 1,0,1 with two words: exactly two aligned tag advances
        step(); start = 1'b1; total_words = 16'd2; row_tag = 4'd0; col_tag = 5'd0;
        tp0 = tag_pulses;
        step(); start = 1'b0; in_valid = 1'b1; in_data = 16'hC000;
        settle();
        chk("p3_c1_tag_en", NPE'(tag_enable), NPE'(1));
        step(); in_valid = 1'b0;
        settle();
        chk("p3_c2_tag_en", NPE'(tag_enable), '0);
        chk("p3_c2_pe_en", pe_enable, bit_at(0));
        step(); in_valid = 1'b1; in_data = 16'hC001;
        settle();
        chk("p3_c3_tag_en", NPE'(tag_enable), NPE'(1));
        step();
        settle();
        chk("p3_c4_tag_en", NPE'(tag_enable), '0);
        chk("p3_c4_pe_en", pe_enable, bit_at(0));
        step(); in_valid = 1'b0;
        settle();
        chk("p3_done", NPE'(done), NPE'(1));
        chk("p3_tag_count", NPE'(tag_pulses - tp0), NPE'(2));

        // start while in RUN is ignored: a one-word pass stays one word
        step(); start = 1'b1; total_words = 16'd1;
        step(); total_words = 16'd9; in_valid = 1'b1; in_data = 16'hD000;
        settle();
        chk("p4_acc", NPE'(tag_enable), NPE'(1));
        step(); start = 1'b0;
        settle();
        chk("p4_in_ready", NPE'(in_ready), '0);
        chk("p4_pe_en", pe_enable, bit_at(0));
        step(); in_valid = 1'b0;
        settle();
        chk("p4_done", NPE'(done), NPE'(1));

        // Reset while a word is held: everything drops at once
        step(); start = 1'b1; total_words = 16'd3;
        step(); start = 1'b0; in_valid = 1'b1; in_data = 16'hE000;
        step(); in_data = 16'hE001;
        settle();
        chk("p5_pre_data", NPE'(out_data), NPE'(16'hE000));
        reset_n = 1'b0;
        settle();
        chk("p5_rst_pe_en", pe_enable, '0);
        chk("p5_rst_in_ready", NPE'(in_ready), '0);
        chk("p5_rst_tag_en", NPE'(tag_enable), '0);
        chk("p5_rst_busy", NPE'(busy), '0);
        chk("p5_rst_data", NPE'(out_data), '0);
        step(); reset_n = 1'b1;
        settle();
        chk("p5_post_in_ready", NPE'(in_ready), '0);
        chk("p5_post_pe_en", pe_enable, '0);
        chk("p5_post_busy", NPE'(busy), '0);

        // Empty pass: straight to done with no handshakes
        step(); start = 1'b1; total_words = 16'd0;
        tp0 = tag_pulses;
        step(); start = 1'b0;
        settle();
        chk("p6_run_in_ready", NPE'(in_ready), '0);
        chk("p6_run_tag_en", NPE'(tag_enable), '0);
        chk("p6_run_busy", NPE'(busy), NPE'(1));
        step();
        settle();
        chk("p6_done", NPE'(done), NPE'(1));
        chk("p6_in_ready", NPE'(in_ready), '0);
        step();
        settle();
        chk("p6_after_done", NPE'(done), '0);
        chk("p6_after_busy", NPE'(busy), '0);
        chk("p6_tag_count", NPE'(tag_pulses - tp0), '0);
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
